psum_gbf_multibank: RTL

- Parametrised successor of the two-bank psum global buffer feeding the accelerator top.
- Holds NUM_BANK psum banks, each PSUM_GBF_DEPTH x PSUM_GBF_DATA_BITWIDTH.
- Write port: lane-wise accumulate or overwrite of spatially-summed PE outputs.
- Per-bank lifecycle CLEAR -> FILL -> FULL -> DRAIN. Completed banks are drained to the output side over a valid/ready stream while other banks keep filling.

---
 rtl/psum_gbf_multibank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/psum_gbf_multibank.sv
// psum_gbf_multibank: NUM_BANK psum buffer banks with CLEAR/FILL/FULL/DRAIN lifecycle and a stream drain.
// Define PSUM_SATURATE_EN to make accumulate lanes saturate instead of wrap.
module psum_gbf_multibank #(
  parameter int OUT_BITWIDTH = 16,
  parameter int PSUM_GBF_DATA_BITWIDTH = 512,
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PSUM_GBF_DEPTH = 32,
  parameter int NUM_BANK = 2,
  parameter int BANK_BITWIDTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [BANK_BITWIDTH-1:0] wr_bank,
  input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] wr_addr,
  input  logic wr_accum,
  input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] wr_data,
  input  logic bank_done,
  input  logic [BANK_BITWIDTH-1:0] bank_done_id,
  output logic drain_valid,
  input  logic drain_ready,
  output logic [PSUM_GBF_DATA_BITWIDTH-1:0] drain_data,
  output logic [BANK_BITWIDTH-1:0] drain_bank,
  output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] drain_addr,
  output logic drain_last,
  output logic [NUM_BANK-1:0] bank_fill,
  output logic err
);
  localparam int OW = OUT_BITWIDTH;
  localparam int DW = PSUM_GBF_DATA_BITWIDTH;
  localparam int AW = PSUM_GBF_ADDR_BITWIDTH;
  localparam int BW = BANK_BITWIDTH;
  localparam int LANES = DW / OW;
  typedef enum logic [2:0] {CLEAR, FILL, CLOSE, FULL, DRAIN} bank_state_t;
  bank_state_t st [NUM_BANK];
  logic [DW-1:0] mem [NUM_BANK][PSUM_GBF_DEPTH];
  logic [AW-1:0] clr_ptr, dptr;
  logic [BW-1:0] dbank, pick;
  logic busy, pick_ok, free, fetch, last_acc, wr_fire;
  logic s1_valid, s1_accum;
  logic [BW-1:0] s1_bank;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data, s1_old, s1_res;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [OW-1:0] x, y;
`ifdef PSUM_SATURATE_EN
    logic [OW:0] s;
`endif
    lane_add = '0;
    for (int l = 0; l < LANES; l++) begin
      x = a[l*OW +: OW];
      y = b[l*OW +: OW];
`ifdef PSUM_SATURATE_EN
      s = {x[OW-1], x} + {y[OW-1], y};
      lane_add[l*OW +: OW] = (s[OW] != s[OW-1]) ? {s[OW], {(OW-1){~s[OW]}}} : s[OW-1:0];
`else
      lane_add[l*OW +: OW] = x + y;
`endif
    end
  endfunction

  always_comb begin
    bank_fill = '0;
    pick_ok = 1'b0;
    pick = '0;
    for (int i = NUM_BANK - 1; i >= 0; i--) begin
      bank_fill[i] = st[i] == FILL;
      if (st[i] == FULL) begin
        pick_ok = 1'b1;
        pick = BW'(i);
      end
    end
  end

  assign wr_ready = bank_fill[wr_bank];
  assign wr_fire = wr_valid && wr_ready;
  assign s1_res = s1_accum ? lane_add(s1_old, s1_data) : s1_data;
  assign last_acc = drain_valid && drain_ready && drain_last;
  // The arbiter may hand over in the same cycle the last beat leaves, giving a single bubble.
  assign free = !busy || last_acc;
  assign fetch = busy && (!drain_valid || (drain_ready && !drain_last));

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANK; b++)
      if (st[b] == CLEAR) mem[b][clr_ptr] <= '0;
    if (s1_valid) mem[s1_bank][s1_addr] <= s1_res;
    if (fetch) mem[dbank][dptr] <= '0;
    if (wr_fire) begin
      s1_bank <= wr_bank;
      s1_addr <= wr_addr;
      s1_accum <= wr_accum;
      s1_data <= wr_data;
      s1_old <= (s1_valid && s1_bank == wr_bank && s1_addr == wr_addr) ? s1_res : mem[wr_bank][wr_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANK; i++) st[i] <= CLEAR;
      clr_ptr <= '0;
      s1_valid <= 1'b0;
      busy <= 1'b0;
      dbank <= '0;
      dptr <= '0;
      err <= 1'b0;
      drain_valid <= 1'b0;
      drain_data <= '0;
      drain_bank <= '0;
      drain_addr <= '0;
      drain_last <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANK; i++)
        case (st[i])
          CLEAR: if (clr_ptr == AW'(PSUM_GBF_DEPTH - 1)) st[i] <= FILL;
          FILL: if (bank_done && bank_done_id == BW'(i)) st[i] <= CLOSE;
          CLOSE: st[i] <= FULL;
          FULL: if (free && pick == BW'(i)) st[i] <= DRAIN;
          DRAIN: if (last_acc) st[i] <= FILL;
          default: st[i] <= CLEAR;
        endcase
      if (st[0] == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      s1_valid <= wr_fire;
      err <= err | (wr_valid && !wr_ready) | (bank_done && !bank_fill[bank_done_id]);
      if (free) begin
        busy <= pick_ok;
        dbank <= pick;
      end
      if (fetch) begin
        dptr <= dptr + 1'b1;
        drain_valid <= 1'b1;
        drain_data <= mem[dbank][dptr];
        drain_bank <= dbank;
        drain_addr <= dptr;
        drain_last <= dptr == AW'(PSUM_GBF_DEPTH - 1);
      end else if (drain_ready) begin
        drain_valid <= 1'b0;
      end
    end
  end
endmodule
